// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_if
// Description : Signal bundle between the host link / program memory / core
//               side and the serial program-memory loader.
//               master : host side (drives the serial link, observes status)
//               slave  : loader side (consumes the link, drives memory/status)
//   load_en      host load window, level-sensitive
//   bit_valid    sdata valid this cycle
//   sdata        serial opcode bit, LSB first
//   prog_we      one-cycle write strobe to program memory
//   prog_addr    write address
//   prog_data    write data
//   cpu_hold     holds the core in reset while high
//   busy / done  loader is shifting / load window finished
//   err_partial  sticky: window closed mid-word
//   err_ovf      sticky: bits offered after memory full
//   word_cnt     words written this load
//   checksum     sum of written words, mod 2^OPCODE_W
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_loader_if #(
  parameter int OPCODE_W = 14,
  parameter int ADDR_W   = 11
);
  logic                load_en;
  logic                bit_valid;
  logic                sdata;
  logic                prog_we;
  logic [ADDR_W-1:0]   prog_addr;
  logic [OPCODE_W-1:0] prog_data;
  logic                cpu_hold;
  logic                busy;
  logic                done;
  logic                err_partial;
  logic                err_ovf;
  logic [ADDR_W:0]     word_cnt;
  logic [OPCODE_W-1:0] checksum;

  modport master (
    output load_en, bit_valid, sdata,
    input  prog_we, prog_addr, prog_data, cpu_hold, busy, done,
           err_partial, err_ovf, word_cnt, checksum
  );

  modport slave (
    input  load_en, bit_valid, sdata,
    output prog_we, prog_addr, prog_data, cpu_hold, busy, done,
           err_partial, err_ovf, word_cnt, checksum
  );
endinterface
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Serial program-memory loader. Shifts opcodes in LSB first,
//               writes each completed word to program memory with a one-cycle
//               strobe, holds the core while loading, and reports word count,
//               running checksum and sticky error flags.
// Ports       : clk    system clock, rising edge
//               reset  asynchronous, active-low
//               bus    prog_loader_if.slave (serial link, memory write port,
//                      core hold and status outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
  parameter int OPCODE_W = 14,
  parameter int ADDR_W   = 11,
  parameter int DEPTH    = 2048
) (
  input  logic         clk,
  input  logic         reset,
  prog_loader_if.slave bus
);

  localparam int                  c_cnt_w     = (OPCODE_W > 1) ? $clog2(OPCODE_W) : 1;
  localparam logic [c_cnt_w-1:0]  c_last_bit  = c_cnt_w'(OPCODE_W - 1);
  localparam logic [ADDR_W-1:0]   c_last_addr = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state_q,       state_d;
  logic [OPCODE_W-1:0] shreg_q,       shreg_d;
  logic [c_cnt_w-1:0]  bit_cnt_q,     bit_cnt_d;
  logic                prog_we_q,     prog_we_d;
  logic [ADDR_W-1:0]   prog_addr_q,   prog_addr_d;
  logic [OPCODE_W-1:0] prog_data_q,   prog_data_d;
  logic                cpu_hold_q,    cpu_hold_d;
  logic                busy_q,        busy_d;
  logic                done_q,        done_d;
  logic                err_partial_q, err_partial_d;
  logic                err_ovf_q,     err_ovf_d;
  logic [ADDR_W:0]     word_cnt_q,    word_cnt_d;
  logic [OPCODE_W-1:0] checksum_q,    checksum_d;
  // Last address has been written; leave SHIFT once its strobe cycle ends.
  logic                full_q,        full_d;

  logic [OPCODE_W-1:0] w_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      prog_we_q     <= 1'b0;
      prog_addr_q   <= '0;
      prog_data_q   <= '0;
      cpu_hold_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_partial_q <= 1'b0;
      err_ovf_q     <= 1'b0;
      word_cnt_q    <= '0;
      checksum_q    <= '0;
      full_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      prog_we_q     <= prog_we_d;
      prog_addr_q   <= prog_addr_d;
      prog_data_q   <= prog_data_d;
      cpu_hold_q    <= cpu_hold_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_partial_q <= err_partial_d;
      err_ovf_q     <= err_ovf_d;
      word_cnt_q    <= word_cnt_d;
      checksum_q    <= checksum_d;
      full_q        <= full_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    prog_we_d     = 1'b0;
    prog_addr_d   = prog_addr_q;
    prog_data_d   = prog_data_q;
    err_partial_d = err_partial_q;
    err_ovf_d     = err_ovf_q;
    word_cnt_d    = word_cnt_q;
    checksum_d    = checksum_q;
    full_d        = full_q;

    // Shift register with the currently offered bit merged in at bit_cnt.
    w_word            = shreg_q;
    w_word[bit_cnt_q] = bus.sdata;

    // The address advances as the strobe drops, so it stays stable for the
    // whole strobe cycle. The last address is held once reached.
    if (prog_we_q && (prog_addr_q != c_last_addr)) begin
      prog_addr_d = prog_addr_q + ADDR_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.load_en) begin
          state_d       = ST_SHIFT;
          shreg_d       = '0;
          bit_cnt_d     = '0;
          prog_addr_d   = '0;
          err_partial_d = 1'b0;
          err_ovf_d     = 1'b0;
          word_cnt_d    = '0;
          checksum_d    = '0;
          full_d        = 1'b0;
        end
      end

      ST_SHIFT: begin
        if (!bus.load_en) begin
          // Window closed: any bit offered now is ignored, partial word lost.
          state_d   = ST_DONE;
          shreg_d   = '0;
          bit_cnt_d = '0;
          if (bit_cnt_q != '0) begin
            err_partial_d = 1'b1;
          end
        end else if (full_q) begin
          // Strobe for the last address has just been issued.
          state_d = ST_DONE;
          if (bus.bit_valid) begin
            err_ovf_d = 1'b1;
          end
        end else if (bus.bit_valid) begin
          if (bit_cnt_q == c_last_bit) begin
            prog_data_d = w_word;
            prog_we_d   = 1'b1;
            shreg_d     = '0;
            bit_cnt_d   = '0;
            checksum_d  = checksum_q + w_word;
            word_cnt_d  = word_cnt_q + (ADDR_W + 1)'(1);
            if (prog_addr_q == c_last_addr) begin
              full_d = 1'b1;
            end
          end else begin
            shreg_d   = w_word;
            bit_cnt_d = bit_cnt_q + c_cnt_w'(1);
          end
        end
      end

      ST_DONE: begin
        if (!bus.load_en) begin
          state_d = ST_IDLE;
        end else if (bus.bit_valid) begin
          err_ovf_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered copies of the next state.
    cpu_hold_d = (state_d != ST_IDLE);
    busy_d     = (state_d == ST_SHIFT);
    done_d     = (state_d == ST_DONE);
  end

  assign bus.prog_we     = prog_we_q;
  assign bus.prog_addr   = prog_addr_q;
  assign bus.prog_data   = prog_data_q;
  assign bus.cpu_hold    = cpu_hold_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err_partial = err_partial_q;
  assign bus.err_ovf     = err_ovf_q;
  assign bus.word_cnt    = word_cnt_q;
  assign bus.checksum    = checksum_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader. Two instances (full-size
//               and a 4-word memory) receive identical stimulus; a word-level
//               reference model predicts every output after every edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

  localparam int OPW     = 14;
  localparam int AW_B    = 11;
  localparam int DEPTH_B = 2048;
  localparam int AW_S    = 2;
  localparam int DEPTH_S = 4;

  localparam int PH_IDLE   = 0;
  localparam int PH_LOAD   = 1;
  localparam int PH_CLOSED = 2;

  logic clk = 1'b0;
  logic reset;
  logic load_en;
  logic bit_valid;
  logic sdata;

  always #5 clk = ~clk;

  prog_loader_if #(.OPCODE_W(OPW), .ADDR_W(AW_B)) if_b ();
  prog_loader_if #(.OPCODE_W(OPW), .ADDR_W(AW_S)) if_s ();

  assign if_b.load_en   = load_en;
  assign if_b.bit_valid = bit_valid;
  assign if_b.sdata     = sdata;
  assign if_s.load_en   = load_en;
  assign if_s.bit_valid = bit_valid;
  assign if_s.sdata     = sdata;

  prog_loader #(.OPCODE_W(OPW), .ADDR_W(AW_B), .DEPTH(DEPTH_B)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b)
  );

  prog_loader #(.OPCODE_W(OPW), .ADDR_W(AW_S), .DEPTH(DEPTH_S)) u_dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (if_s)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model, one slot per instance: 0 = full size, 1 = 4 words.
  int m_depth [2] = '{DEPTH_B, DEPTH_S};
  int m_ph    [2];
  int m_nbits [2];   // bits collected toward the current word
  int m_acc   [2];   // value of the partial word
  int m_nw    [2];   // words written this load
  int m_sum   [2];
  int m_last  [2];   // last word written since reset
  bit m_ep    [2];
  bit m_eo    [2];
  bit m_we    [2];   // a word completed at the most recent edge

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset(input int d);
    m_ph[d] = PH_IDLE; m_nbits[d] = 0; m_acc[d] = 0; m_nw[d] = 0;
    m_sum[d] = 0; m_last[d] = 0; m_ep[d] = 1'b0; m_eo[d] = 1'b0; m_we[d] = 1'b0;
  endfunction

  function automatic void model_step(input int d, input bit le, input bit bv, input bit sd);
    m_we[d] = 1'b0;
    case (m_ph[d])
      PH_IDLE: begin
        if (le) begin
          m_ph[d] = PH_LOAD; m_nbits[d] = 0; m_acc[d] = 0; m_nw[d] = 0;
          m_sum[d] = 0; m_ep[d] = 1'b0; m_eo[d] = 1'b0;
        end
      end
      PH_LOAD: begin
        if (!le) begin
          m_ph[d] = PH_CLOSED;
          if (m_nbits[d] != 0) m_ep[d] = 1'b1;
          m_nbits[d] = 0; m_acc[d] = 0;
        end else if (m_nw[d] == m_depth[d]) begin
          m_ph[d] = PH_CLOSED;
          if (bv) m_eo[d] = 1'b1;
        end else if (bv) begin
          m_acc[d] = m_acc[d] + (int'(sd) << m_nbits[d]);
          m_nbits[d]++;
          if (m_nbits[d] == OPW) begin
            m_nw[d]++;
            m_sum[d]   = (m_sum[d] + m_acc[d]) % (1 << OPW);
            m_last[d]  = m_acc[d];
            m_we[d]    = 1'b1;
            m_nbits[d] = 0;
            m_acc[d]   = 0;
          end
        end
      end
      default: begin
        if (!le) m_ph[d] = PH_IDLE;
        else if (bv) m_eo[d] = 1'b1;
      end
    endcase
  endfunction

  // Address of the word being strobed, otherwise the next free slot,
  // saturating at the last address.
  function automatic int exp_addr(input int d);
    if (m_we[d]) return m_nw[d] - 1;
    if (m_nw[d] == 0) return 0;
    return (m_nw[d] < m_depth[d] - 1) ? m_nw[d] : m_depth[d] - 1;
  endfunction

  task automatic check_dut(input int d, input string nm,
                           input logic we, input logic [31:0] addr, input logic [31:0] data,
                           input logic hold, input logic busy, input logic done,
                           input logic ep, input logic eo,
                           input logic [31:0] wc, input logic [31:0] cs);
    chk_eq({nm, ".prog_we"},     32'(we),   32'(m_we[d]));
    chk_eq({nm, ".prog_addr"},   addr,      32'(exp_addr(d)));
    chk_eq({nm, ".prog_data"},   data,      32'(m_last[d]));
    chk_eq({nm, ".cpu_hold"},    32'(hold), 32'(m_ph[d] != PH_IDLE));
    chk_eq({nm, ".busy"},        32'(busy), 32'(m_ph[d] == PH_LOAD));
    chk_eq({nm, ".done"},        32'(done), 32'(m_ph[d] == PH_CLOSED));
    chk_eq({nm, ".err_partial"}, 32'(ep),   32'(m_ep[d]));
    chk_eq({nm, ".err_ovf"},     32'(eo),   32'(m_eo[d]));
    chk_eq({nm, ".word_cnt"},    wc,        32'(m_nw[d]));
    chk_eq({nm, ".checksum"},    cs,        32'(m_sum[d]));
  endtask

  task automatic check_both();
    check_dut(0, "big", if_b.prog_we, 32'(if_b.prog_addr), 32'(if_b.prog_data),
              if_b.cpu_hold, if_b.busy, if_b.done, if_b.err_partial, if_b.err_ovf,
              32'(if_b.word_cnt), 32'(if_b.checksum));
    check_dut(1, "small", if_s.prog_we, 32'(if_s.prog_addr), 32'(if_s.prog_data),
              if_s.cpu_hold, if_s.busy, if_s.done, if_s.err_partial, if_s.err_ovf,
              32'(if_s.word_cnt), 32'(if_s.checksum));
  endtask

  task automatic cycle(input bit le, input bit bv, input bit sd);
    load_en = le; bit_valid = bv; sdata = sd;
    @(posedge clk);
    model_step(0, le, bv, sd);
    model_step(1, le, bv, sd);
    #1;
    check_both();
  endtask

  // mode 0: continuous, 1: gap before every bit, 2: random gaps
  task automatic send_bits(input logic [OPW-1:0] w, input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      if (mode == 1) cycle(1'b1, 1'b0, 1'($urandom));
      else if (mode == 2) repeat ($urandom_range(0, 2)) cycle(1'b1, 1'b0, 1'($urandom));
      cycle(1'b1, 1'b1, w[i]);
    end
  endtask

  task automatic send_word(input logic [OPW-1:0] w, input int mode);
    send_bits(w, OPW, mode);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; load_en = 1'b0; bit_valid = 1'b0; sdata = 1'b0;
    model_reset(0); model_reset(1);
    repeat (2) @(posedge clk);
    #1;
    check_both();
    #3 reset = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);

    // Three words, continuous bits.
    cycle(1'b1, 1'b0, 1'b0);
    send_word(14'h3FFF, 0);
    send_word(14'h0000, 0);
    send_word(14'h1234, 0);
    cycle(1'b1, 1'b0, 1'b0);
    chk_eq("t1.word_cnt", 32'(if_b.word_cnt), 32'd3);
    chk_eq("t1.checksum", 32'(if_b.checksum), 32'h1233);
    chk_eq("t1.cpu_hold", 32'(if_b.cpu_hold), 32'd1);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk_eq("t1.cpu_hold_released", 32'(if_b.cpu_hold), 32'd0);

    // One word with bit_valid toggling.
    cycle(1'b1, 1'b0, 1'b0);
    send_word(14'h2A5C, 1);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk_eq("t2.prog_data", 32'(if_b.prog_data), 32'h2A5C);
    chk_eq("t2.word_cnt",  32'(if_b.word_cnt),  32'd1);
    cycle(1'b0, 1'b0, 1'b0);

    // Window closes after one word plus five bits.
    cycle(1'b1, 1'b0, 1'b0);
    send_word(14'($urandom), 0);
    send_bits(14'($urandom), 5, 0);
    cycle(1'b0, 1'b1, 1'b1);
    chk_eq("t3.err_partial", 32'(if_b.err_partial), 32'd1);
    chk_eq("t3.word_cnt",    32'(if_b.word_cnt),    32'd1);
    chk_eq("t3.done",        32'(if_b.done),        32'd1);
    cycle(1'b0, 1'b0, 1'b0);

    // Five words: the 4-word instance fills and flags overflow.
    cycle(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) send_word(14'($urandom), 0);
    cycle(1'b1, 1'b0, 1'b0);
    chk_eq("t4.small.err_ovf",   32'(if_s.err_ovf),   32'd1);
    chk_eq("t4.small.word_cnt",  32'(if_s.word_cnt),  32'd4);
    chk_eq("t4.small.prog_addr", 32'(if_s.prog_addr), 32'd3);
    chk_eq("t4.big.word_cnt",    32'(if_b.word_cnt),  32'd5);
    chk_eq("t4.big.err_ovf",     32'(if_b.err_ovf),   32'd0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);

    // Asynchronous reset at bit 9 of word 2.
    cycle(1'b1, 1'b0, 1'b0);
    send_word(14'($urandom), 0);
    send_bits(14'($urandom), 9, 0);
    load_en = 1'b1; bit_valid = 1'b1; sdata = 1'b1;
    #2 reset = 1'b0;
    #1;
    model_reset(0); model_reset(1);
    check_both();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_both();
    end
    #3 reset = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    send_word(14'h0155, 0);
    send_word(14'h2AAA, 2);
    cycle(1'b1, 1'b0, 1'b0);
    chk_eq("t5.prog_addr", 32'(if_b.prog_addr), 32'd2);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);

    // Random loads.
    repeat (25) begin
      int nw;
      int mode;
      nw   = $urandom_range(0, 6);
      mode = $urandom_range(0, 2);
      cycle(1'b1, 1'($urandom), 1'($urandom));
      for (int k = 0; k < nw; k++) send_word(14'($urandom), mode);
      if ($urandom_range(0, 1) == 1) send_bits(14'($urandom), $urandom_range(1, OPW - 1), mode);
      repeat ($urandom_range(0, 3)) cycle(1'b1, 1'($urandom), 1'($urandom));
      repeat ($urandom_range(1, 3)) cycle(1'b0, 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) cycle(1'b0, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
